// File: rtl/adam_pause_seq_pkg.sv
// Shared types and helpers for the ADAM pause sequencer.
package adam_pause_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_PAUSING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_RESUMING = 2'd3
  } state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int IDX_WIDTH(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adam_pause_seq.sv
// ADAM pause initiator: fans one upstream pause req/ack out to NO_SLVS
// downstream channels, pausing 0..N-1 in order and resuming in reverse.
module adam_pause_seq
  import adam_pause_seq_pkg::*;
#(
  parameter  int NO_SLVS    = 4,
  parameter  int TIMEOUT    = 1024,
  parameter  int RST_PAUSED = 1,
  localparam int IW         = IDX_WIDTH(NO_SLVS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_slv_pause_req,
  output logic               o_slv_pause_ack,
  output logic [NO_SLVS-1:0] o_mst_pause_req,
  input  logic [NO_SLVS-1:0] i_mst_pause_ack,
  output logic               o_busy,
  output logic               o_err,
  output logic [IW-1:0]      o_err_idx
);

  localparam logic [IW-1:0] LAST = IW'(NO_SLVS - 1);
  localparam logic          RSTP = (RST_PAUSED != 0);

  state_e               r_state, w_state_nxt;
  logic [IW-1:0]        r_idx, w_idx_nxt;
  logic [NO_SLVS-1:0]   r_mst_req, w_req_nxt;
  logic                 r_slv_ack, w_ack_nxt;
  logic                 r_busy;
  logic                 w_hit;  // expected ack seen for the active channel

  // Next-state: advance one channel per observed ack; upstream req only
  // looked at in the two stable states, so toggles mid-sequence are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_req_nxt   = r_mst_req;
    w_ack_nxt   = r_slv_ack;
    w_hit       = 1'b0;
    unique case (r_state)
      ST_RUN: if (i_slv_pause_req) begin
        w_state_nxt  = ST_PAUSING;
        w_idx_nxt    = '0;
        w_req_nxt[0] = 1'b1;
      end
      ST_PAUSING: if (i_mst_pause_ack[r_idx]) begin
        w_hit = 1'b1;
        if (r_idx != LAST) begin
          w_idx_nxt            = r_idx + 1'b1;
          w_req_nxt[w_idx_nxt] = 1'b1;
        end else begin
          w_state_nxt = ST_PAUSED;
          w_ack_nxt   = 1'b1;
        end
      end
      ST_PAUSED: if (!i_slv_pause_req) begin
        w_state_nxt     = ST_RESUMING;
        w_idx_nxt       = LAST;
        w_req_nxt[LAST] = 1'b0;
      end
      ST_RESUMING: if (!i_mst_pause_ack[r_idx]) begin
        w_hit = 1'b1;
        if (r_idx != '0) begin
          w_idx_nxt            = r_idx - 1'b1;
          w_req_nxt[w_idx_nxt] = 1'b0;
        end else begin
          w_state_nxt = ST_RUN;
          w_ack_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and output registers; reset lands in PAUSED or RUN per RST_PAUSED.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RSTP ? ST_PAUSED : ST_RUN;
      r_idx     <= '0;
      r_mst_req <= {NO_SLVS{RSTP}};
      r_slv_ack <= RSTP;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_mst_req <= w_req_nxt;
      r_slv_ack <= w_ack_nxt;
      r_busy    <= (w_state_nxt == ST_PAUSING) || (w_state_nxt == ST_RESUMING);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
      logic [CW-1:0] r_cnt;
      logic          r_err;
      logic [IW-1:0] r_err_idx;

      // Per-step wait counter (saturating); first channel to stall is latched.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt     <= '0;
          r_err     <= 1'b0;
          r_err_idx <= '0;
        end else if (r_busy && !w_hit) begin
          if (r_cnt != CMAX) r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CMAX && !r_err) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign o_err     = r_err;
      assign o_err_idx = r_err_idx;
    end else begin : g_no_tmo
      assign o_err     = 1'b0;
      assign o_err_idx = '0;
    end
  endgenerate

  assign o_slv_pause_ack = r_slv_ack;
  assign o_mst_pause_req = r_mst_req;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Randomized bench for adam_pause_seq: an event-schedule model predicts the
// edge at which every output changes from the responder delays.
module tb_adam_pause_seq;
  localparam int N   = 3;
  localparam int T   = 8;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         slv_req, slv_ack, busy, err;
  logic [N-1:0] mreq, mack;
  logic [1:0]   eidx;

  logic         slv_req1, slv_ack1, busy1, err1;
  logic [0:0]   mreq1, mack1, eidx1;

  adam_pause_seq #(.NO_SLVS(N), .TIMEOUT(T), .RST_PAUSED(1)) u_dut (
    .clk(clk), .rst(rst),
    .i_slv_pause_req(slv_req), .o_slv_pause_ack(slv_ack),
    .o_mst_pause_req(mreq), .i_mst_pause_ack(mack),
    .o_busy(busy), .o_err(err), .o_err_idx(eidx));

  adam_pause_seq #(.NO_SLVS(1), .TIMEOUT(0), .RST_PAUSED(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_slv_pause_req(slv_req1), .o_slv_pause_ack(slv_ack1),
    .o_mst_pause_req(mreq1), .i_mst_pause_ack(mack1),
    .o_busy(busy1), .o_err(err1), .o_err_idx(eidx1));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: per-channel edge at which req takes the level 'dir'.
  bit dir;
  int r_t[N];
  int done_t, start_t, err_t, err_ch;

  // Responders: ack follows req rd[i] cycles after the req edge.
  int           rd[N];
  int           chg[N];
  logic [N-1:0] prev_req;
  logic         prev_req1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  task automatic model_rst();
    dir = 1'b1;
    for (int i = 0; i < N; i++) r_t[i] = 0;
    done_t  = 0;
    start_t = INF;
    err_t   = INF;
    err_ch  = 0;
  endtask

  // Build the edge schedule for a sequence whose upstream req changed at s.
  task automatic sched(input bit d, input int s);
    int t;
    t = s + 1;
    for (int k = 0; k < N; k++) begin
      int ch;
      ch = d ? k : N - 1 - k;
      r_t[ch] = t;
      if (rd[ch] >= T && err_t == INF) begin
        err_t  = t + T;
        err_ch = ch;
      end
      t = t + rd[ch] + 1;
    end
    done_t  = t;
    start_t = s;
    dir     = d;
  endtask

  task automatic step();
    logic [N-1:0] ereq;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) ereq[i] = (cyc >= r_t[i]) ? dir : !dir;
    chk("mst_req", 32'(mreq), 32'(ereq));
    chk("slv_ack", 32'(slv_ack), 32'((cyc >= done_t) ? dir : !dir));
    chk("busy", 32'(busy), 32'(cyc > start_t && cyc < done_t));
    chk("err", 32'(err), 32'(cyc >= err_t));
    chk("err_idx", 32'(eidx), (cyc >= err_t) ? 32'(err_ch) : 32'd0);
    for (int i = 0; i < N; i++) begin
      if (mreq[i] !== prev_req[i]) chg[i] = cyc;
      if (mack[i] !== mreq[i] && cyc - chg[i] >= rd[i]) mack[i] = mreq[i];
    end
    prev_req  = mreq;
    mack1     = prev_req1;
    prev_req1 = mreq1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    slv_req  = 1'b1;
    mack     = '1;
    prev_req = '1;
    model_rst();
    step();
    rst = 1'b0;
  endtask

  // mode 0: random delays; 1: all one; 2: all one but channel 2 stalls past T.
  task automatic run_seq(input bit d, input bit set_req, input int tog_off,
                         input int rst_off, input int mode);
    int s;
    for (int i = 0; i < N; i++) begin
      if (mode == 0)
        rd[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 3) : $urandom_range(1, T - 1);
      else
        rd[i] = 1;
    end
    if (mode == 2) rd[2] = T + 2;
    s = cyc;
    if (set_req) slv_req = d;
    sched(d, s);
    while (cyc < done_t) begin
      step();
      if (tog_off > 0 && cyc == s + tog_off) slv_req = !d;
      if (rst_off > 0 && cyc == s + rst_off) begin
        do_reset();
        return;
      end
    end
  endtask

  // Single-channel, no-timeout, reset-to-RUN instance: fixed 1-cycle responder.
  task automatic u1_phase(input bit v);
    int s;
    s = cyc;
    slv_req1 = v;
    repeat (5) begin
      step();
      chk("u1_req", 32'(mreq1), 32'((cyc >= s + 1) ? v : !v));
      chk("u1_ack", 32'(slv_ack1), 32'((cyc >= s + 3) ? v : !v));
      chk("u1_busy", 32'(busy1), 32'(cyc == s + 1 || cyc == s + 2));
      chk("u1_err", 32'({err1, eidx1}), 32'd0);
    end
  endtask

  initial begin
    slv_req   = 1'b1;
    mack      = '1;
    prev_req  = '1;
    slv_req1  = 1'b0;
    mack1     = '0;
    prev_req1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd[i]  = 1;
      chg[i] = 0;
    end
    model_rst();
    step();
    step();
    rst = 1'b0;
    chk("u1_rst", 32'({mreq1, slv_ack1, busy1, err1}), 32'd0);

    u1_phase(1'b1);
    u1_phase(1'b0);

    run_seq(1'b0, 1'b1, 0, 0, 1);   // release from reset-paused, 1-cycle acks
    run_seq(1'b1, 1'b1, 0, 0, 1);   // pause, 1-cycle acks
    run_seq(1'b0, 1'b1, 0, 0, 1);
    run_seq(1'b1, 1'b1, 0, 0, 2);   // channel 2 times out, late ack completes
    run_seq(1'b0, 1'b1, 0, 0, 0);   // err must stay sticky
    run_seq(1'b1, 1'b1, 0, 4, 1);   // reset while pausing channel 1
    repeat (3) step();
    run_seq(1'b0, 1'b1, 2, 0, 1);   // upstream re-raises mid-resume
    run_seq(1'b1, 1'b0, 0, 0, 0);   // ...so a pause follows right after

    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      run_seq(!dir, 1'b1, 0, $urandom_range(1, 6), 0);
      else if (r == 1) begin
        run_seq(!dir, 1'b1, $urandom_range(1, 5), 0, 0);
        run_seq(!dir, 1'b0, 0, 0, 0);
      end
      else             run_seq(!dir, 1'b1, 0, 0, 0);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
